// File: rtl/mult_pattern_detect_pipe_pkg.sv
// mpd_pkg: shared definitions for the multiplier pattern detector.
//   mode_t  - 2-bit compare mode held in the config register and decoded by
//             mpd_compare.
package mpd_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT  = 2'd0,   // full-width equality, mask ignored
        MODE_MASK   = 2'd1,   // equality on unmasked bits
        MODE_BAR    = 2'd2,   // unmasked bits equal the complement of pattern
        MODE_EITHER = 2'd3    // MODE_MASK or MODE_BAR
    } mode_t;

endpackage

// File: rtl/mult_pattern_detect_pipe_if.sv
// mult_pattern_detect_pipe_if: operand, configuration and result signals of
// the multiplier pattern detector.
//   master - operand/config source (drives in_valid, a, b, cfg_*, clear)
//   slave  - the detector (drives out_valid, product, match, match_bar,
//            sticky, match_count)
interface mult_pattern_detect_pipe_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) ();

    logic                in_valid;
    logic [DW-1:0]       a;
    logic [DW-1:0]       b;
    logic                cfg_load;
    logic [2*DW-1:0]     cfg_pattern;
    logic [2*DW-1:0]     cfg_mask;
    logic [1:0]          cfg_mode;
    logic                clear;

    logic                out_valid;
    logic [2*DW-1:0]     product;
    logic                match;
    logic                match_bar;
    logic                sticky;
    logic [CNT_W-1:0]    match_count;

    modport master (
        output in_valid, a, b, cfg_load, cfg_pattern, cfg_mask, cfg_mode, clear,
        input  out_valid, product, match, match_bar, sticky, match_count
    );

    modport slave (
        input  in_valid, a, b, cfg_load, cfg_pattern, cfg_mask, cfg_mode, clear,
        output out_valid, product, match, match_bar, sticky, match_count
    );

endinterface

// File: rtl/mult_pattern_detect_pipe_compare.sv
// mpd_compare: combinational pattern compare of a product.
//   product, pattern, mask (1 = don't care) : PW bits in
//   mode                                    : mode_t in
//   match     : mode-selected result
//   match_bar : unmasked product bits equal the complement of pattern,
//               always evaluated regardless of mode
module mpd_compare
    import mpd_pkg::*;
#(
    parameter int PW = 16
) (
    input  logic [PW-1:0] product,
    input  logic [PW-1:0] pattern,
    input  logic [PW-1:0] mask,
    input  mode_t         mode,
    output logic          match,
    output logic          match_bar
);

    logic exact_hit;
    logic mask_hit;

    always_comb begin
        exact_hit = (product == pattern);
        mask_hit  = ((product & ~mask) == (pattern & ~mask));
        match_bar = ((product & ~mask) == (~pattern & ~mask));
        match     = 1'b0;
        case (mode)
            MODE_EXACT:  match = exact_hit;
            MODE_MASK:   match = mask_hit;
            MODE_BAR:    match = match_bar;
            MODE_EITHER: match = mask_hit | match_bar;
            default:     match = 1'b0;
        endcase
    end

endmodule

// File: rtl/mult_pattern_detect_pipe.sv
// mult_pattern_detect_pipe: 3-stage unsigned multiplier with a configurable
// pattern detector on the result.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mult_pattern_detect_pipe_if.slave: operands in, config in, clear
//          in; product / match / match_bar / sticky / match_count out
// Stage 1 registers operands, stage 2 the raw product, stage 3 the product
// together with its compare result, so match always describes the product
// presented alongside it. The compare uses whatever config is registered
// while the operation sits in stage 2.
module mult_pattern_detect_pipe
    import mpd_pkg::*;
#(
    parameter int              DW       = 8,
    parameter logic [2*DW-1:0] PAT_RST  = 16'd18,
    parameter logic [2*DW-1:0] MASK_RST = 16'd0,
    parameter int              CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    mult_pattern_detect_pipe_if.slave bus
);

    localparam int PW = 2 * DW;

    logic             s1_valid;
    logic [DW-1:0]    s1_a;
    logic [DW-1:0]    s1_b;
    logic             s2_valid;
    logic [PW-1:0]    s2_prod;

    logic [PW-1:0]    pat_q;
    logic [PW-1:0]    mask_q;
    mode_t            mode_q;

    logic             cmp_match;
    logic             cmp_match_bar;

    logic             out_valid_q;
    logic [PW-1:0]    product_q;
    logic             match_q;
    logic             match_bar_q;
    logic             sticky_q;
    logic [CNT_W-1:0] count_q;

    // Operand and raw-product registers only load on valid; they carry no
    // state that matters while their valid bit is low, so they are not reset.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            s1_a <= bus.a;
            s1_b <= bus.b;
        end
        if (s1_valid) begin
            s2_prod <= {{DW{1'b0}}, s1_a} * {{DW{1'b0}}, s1_b};
        end
    end

    mpd_compare #(.PW(PW)) u_compare (
        .product   (s2_prod),
        .pattern   (pat_q),
        .mask      (mask_q),
        .mode      (mode_q),
        .match     (cmp_match),
        .match_bar (cmp_match_bar)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            match_q     <= 1'b0;
            match_bar_q <= 1'b0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
            pat_q       <= PAT_RST;
            mask_q      <= MASK_RST;
            mode_q      <= MODE_EXACT;
        end else begin
            s1_valid    <= bus.in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
            match_q     <= s2_valid & cmp_match;
            match_bar_q <= s2_valid & cmp_match_bar;
            if (s2_valid) begin
                product_q <= s2_prod;
            end

            if (bus.cfg_load) begin
                pat_q  <= bus.cfg_pattern;
                mask_q <= bus.cfg_mask;
                mode_q <= mode_t'(bus.cfg_mode);
            end

            // clear beats a match landing on the same edge; that match is
            // still presented on the match output but never counted.
            if (bus.clear) begin
                sticky_q <= 1'b0;
                count_q  <= '0;
            end else if (s2_valid && cmp_match) begin
                sticky_q <= 1'b1;
                if (count_q != {CNT_W{1'b1}}) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.product     = product_q;
    assign bus.match       = match_q;
    assign bus.match_bar   = match_bar_q;
    assign bus.sticky      = sticky_q;
    assign bus.match_count = count_q;

endmodule
